// File: rtl/clk_period_meter.sv
// Measures rise-to-rise period and rise-to-fall high time of an asynchronous
// clock in clk_in cycles, with sticky no-edge timeout and period lock detection.
//
// state      | meaning
// -----------+--------------------------------------------------------------
// ST_IDLE    | disabled; lock/timeout/good/cnt cleared, results retained
// ST_ARM     | waiting for the first rise to align the interval counter
// ST_MEASURE | counting between rises, capturing the falling-edge count
module clk_period_meter #(
    parameter int CNT_W       = 21,
    parameter int SYNC_STAGES = 2,
    parameter int TIMEOUT     = 1000000,
    parameter int LOCK_TOL    = 1,
    parameter int LOCK_COUNT  = 4
) (
    input  logic             clk_in,
    input  logic             rst_n,
    input  logic             sig_in,
    input  logic             enable,
    input  logic [CNT_W-1:0] exp_period,
    output logic [CNT_W-1:0] period,
    output logic [CNT_W-1:0] high_time,
    output logic             meas_valid,
    output logic             timeout,
    output logic             locked
);

    localparam int ERR_W  = CNT_W + 1;
    localparam int GOOD_W = (LOCK_COUNT < 1) ? 1 : $clog2(LOCK_COUNT + 1);
    localparam logic [GOOD_W-1:0] GOOD_MAX = GOOD_W'(LOCK_COUNT);
    localparam logic [CNT_W-1:0]  CNT_TO   = CNT_W'(TIMEOUT);
    localparam logic [ERR_W-1:0]  ERR_TOL  = ERR_W'(LOCK_TOL);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ARM,
        ST_MEASURE
    } state_t;

    state_t                 state_q;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   hist_q;
    logic [CNT_W-1:0]       cnt_q;
    logic [CNT_W-1:0]       high_q;
    logic [GOOD_W-1:0]      good_q;
    logic [CNT_W-1:0]       period_q;
    logic [CNT_W-1:0]       high_time_q;
    logic                   meas_valid_q;
    logic                   timeout_q;
    logic                   locked_q;

    logic                   sync_out;
    logic                   rise;
    logic                   fall;
    logic [ERR_W-1:0]       err_raw;
    logic [ERR_W-1:0]       err_abs;
    logic                   in_tol;
    logic [GOOD_W-1:0]      good_d;
    logic                   locked_d;

    assign sync_out = sync_q[SYNC_STAGES-1];
    assign rise     = sync_out & ~hist_q;
    assign fall     = ~sync_out & hist_q;

    // Lock bookkeeping for the measurement that would complete this cycle.
    always_comb begin
        err_raw  = {1'b0, cnt_q} - {1'b0, exp_period};
        err_abs  = err_raw[CNT_W] ? (~err_raw + ERR_W'(1)) : err_raw;
        in_tol   = (err_abs <= ERR_TOL);
        good_d   = '0;
        if (in_tol) begin
            good_d = (good_q == GOOD_MAX) ? good_q : good_q + GOOD_W'(1);
        end
        locked_d = in_tol && (good_d == GOOD_MAX);
    end

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            sync_q       <= '0;
            hist_q       <= 1'b0;
            cnt_q        <= '0;
            high_q       <= '0;
            good_q       <= '0;
            period_q     <= '0;
            high_time_q  <= '0;
            meas_valid_q <= 1'b0;
            timeout_q    <= 1'b0;
            locked_q     <= 1'b0;
        end else begin
            sync_q       <= {sync_q[SYNC_STAGES-2:0], sig_in};
            hist_q       <= sync_out;
            meas_valid_q <= 1'b0;
            if (!enable) begin
                state_q   <= ST_IDLE;
                cnt_q     <= '0;
                good_q    <= '0;
                timeout_q <= 1'b0;
                locked_q  <= 1'b0;
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        state_q <= ST_ARM;
                        cnt_q   <= '0;
                    end
                    ST_ARM: begin
                        if (rise) begin
                            state_q <= ST_MEASURE;
                            cnt_q   <= CNT_W'(1);
                        end else if (cnt_q == CNT_TO) begin
                            timeout_q <= 1'b1;
                            locked_q  <= 1'b0;
                            good_q    <= '0;
                            cnt_q     <= '0;
                        end else begin
                            cnt_q <= cnt_q + CNT_W'(1);
                        end
                    end
                    ST_MEASURE: begin
                        if (rise) begin
                            period_q     <= cnt_q;
                            high_time_q  <= high_q;
                            meas_valid_q <= 1'b1;
                            timeout_q    <= 1'b0;
                            good_q       <= good_d;
                            locked_q     <= locked_d;
                            cnt_q        <= CNT_W'(1);
                        end else if (cnt_q == CNT_TO) begin
                            state_q   <= ST_ARM;
                            timeout_q <= 1'b1;
                            locked_q  <= 1'b0;
                            good_q    <= '0;
                            cnt_q     <= '0;
                        end else begin
                            cnt_q <= cnt_q + CNT_W'(1);
                            if (fall) begin
                                high_q <= cnt_q;
                            end
                        end
                    end
                    default: state_q <= ST_IDLE;
                endcase
            end
        end
    end

    assign period     = period_q;
    assign high_time  = high_time_q;
    assign meas_valid = meas_valid_q;
    assign timeout    = timeout_q;
    assign locked     = locked_q;

endmodule

// File: tb/tb_clk_period_meter.sv
// Directed bench for clk_period_meter: synchronous dividers, retune, timeout,
// enable drop, mid-period reset and an asynchronous 7.3-cycle input.
module tb_clk_period_meter;

    localparam int CNT_W = 21;

    logic             clk_in = 1'b0;
    logic             rst_n;
    logic             sig_in;
    logic             enable;
    logic [CNT_W-1:0] exp_period;
    logic [CNT_W-1:0] period;
    logic [CNT_W-1:0] high_time;
    logic             meas_valid;
    logic             timeout;
    logic             locked;

    int n_checks = 0;
    int n_fail   = 0;

    // sig_in generator: 0 = held low, 1 = divide-by-n_div, 2 = async 7.3-cycle period
    int mode     = 0;
    int div_req  = 8;
    int n_div    = 8;
    int ph       = 0;
    int rise_cnt = 0;
    bit async_run = 1'b0;

    clk_period_meter #(
        .CNT_W      (CNT_W),
        .SYNC_STAGES(2),
        .TIMEOUT    (50),
        .LOCK_TOL   (1),
        .LOCK_COUNT (4)
    ) dut (
        .clk_in    (clk_in),
        .rst_n     (rst_n),
        .sig_in    (sig_in),
        .enable    (enable),
        .exp_period(exp_period),
        .period    (period),
        .high_time (high_time),
        .meas_valid(meas_valid),
        .timeout   (timeout),
        .locked    (locked)
    );

    always #50 clk_in = ~clk_in;

    initial begin
        logic nxt;
        sig_in = 1'b0;
        forever begin
            if (mode == 2) begin
                // offset by 1 so async toggles never coincide with a clock edge
                if (!async_run) begin
                    #1;
                    async_run = 1'b1;
                end
                #365;
                if (mode == 2) begin
                    sig_in = ~sig_in;
                    if (sig_in) rise_cnt++;
                end
            end else begin
                async_run = 1'b0;
                @(negedge clk_in);
                if (mode == 1) begin
                    ph++;
                    if (ph >= n_div) begin
                        ph    = 0;
                        n_div = div_req;
                    end
                    nxt = (ph < n_div / 2);
                    if (nxt && !sig_in) rise_cnt++;
                    sig_in = nxt;
                end else if (mode == 0) begin
                    sig_in = 1'b0;
                    n_div  = div_req;
                    ph     = n_div - 1;
                end
            end
        end
    end

    task automatic wait_mv(input int max_cyc, output int cyc, output bit got);
        got = 1'b0;
        cyc = -1;
        for (int i = 1; i <= max_cyc; i++) begin
            @(negedge clk_in);
            if (meas_valid) begin
                got = 1'b1;
                cyc = i;
                return;
            end
        end
    endtask

    task automatic test_reset();
        rst_n      = 1'b0;
        enable     = 1'b0;
        exp_period = '0;
        repeat (3) @(negedge clk_in);
        n_checks++; if (period !== 0)     begin n_fail++; $display("FAIL reset_period: got %0d expected 0", period); end
        n_checks++; if (high_time !== 0)  begin n_fail++; $display("FAIL reset_high: got %0d expected 0", high_time); end
        n_checks++; if (meas_valid !== 0) begin n_fail++; $display("FAIL reset_mv: got %0b expected 0", meas_valid); end
        n_checks++; if (timeout !== 0)    begin n_fail++; $display("FAIL reset_timeout: got %0b expected 0", timeout); end
        n_checks++; if (locked !== 0)     begin n_fail++; $display("FAIL reset_locked: got %0b expected 0", locked); end
        rst_n = 1'b1;
        @(negedge clk_in);
    endtask

    task automatic test_divide8();
        int cyc;
        bit got;
        exp_period = 8;
        div_req    = 8;
        enable     = 1'b1;
        mode       = 1;
        for (int k = 1; k <= 6; k++) begin
            wait_mv((k == 1) ? 40 : 20, cyc, got);
            n_checks++; if (!got) begin n_fail++; $display("FAIL div8_mv%0d: no meas_valid within bound, expected one", k); end
            if (k >= 2) begin
                n_checks++; if (cyc != 8) begin n_fail++; $display("FAIL div8_spacing%0d: got %0d cycles expected 8", k, cyc); end
            end
            n_checks++; if (period !== 8)    begin n_fail++; $display("FAIL div8_period%0d: got %0d expected 8", k, period); end
            n_checks++; if (high_time !== 4) begin n_fail++; $display("FAIL div8_high%0d: got %0d expected 4", k, high_time); end
            n_checks++; if (locked !== (k >= 4)) begin n_fail++; $display("FAIL div8_locked%0d: got %0b expected %0b", k, locked, (k >= 4)); end
        end
    endtask

    task automatic test_switch12();
        int cyc;
        bit got;
        div_req = 12;
        wait_mv(20, cyc, got);
        n_checks++; if (!got || period !== 8) begin n_fail++; $display("FAIL sw_last8: got %0d expected 8", period); end
        n_checks++; if (locked !== 1) begin n_fail++; $display("FAIL sw_last8_locked: got %0b expected 1", locked); end
        wait_mv(20, cyc, got);
        n_checks++; if (!got || cyc != 12) begin n_fail++; $display("FAIL sw_spacing: got %0d cycles expected 12", cyc); end
        n_checks++; if (period !== 12)   begin n_fail++; $display("FAIL sw_period: got %0d expected 12", period); end
        n_checks++; if (high_time !== 6) begin n_fail++; $display("FAIL sw_high: got %0d expected 6", high_time); end
        n_checks++; if (locked !== 0)    begin n_fail++; $display("FAIL sw_unlock: got %0b expected 0", locked); end
        exp_period = 12;
        for (int k = 1; k <= 4; k++) begin
            wait_mv(20, cyc, got);
            n_checks++; if (!got || period !== 12) begin n_fail++; $display("FAIL relock_period%0d: got %0d expected 12", k, period); end
            n_checks++; if (locked !== (k == 4)) begin n_fail++; $display("FAIL relock_locked%0d: got %0b expected %0b", k, locked, (k == 4)); end
        end
    endtask

    task automatic test_timeout();
        int to_cyc = -1;
        int mv_seen = 0;
        int cyc;
        bit got;
        mode = 0;
        for (int c = 1; c <= 120; c++) begin
            @(negedge clk_in);
            if (meas_valid) mv_seen++;
            if (timeout) begin
                to_cyc = c;
                break;
            end
        end
        n_checks++; if (to_cyc != 50) begin n_fail++; $display("FAIL to_delay: got %0d cycles expected 50", to_cyc); end
        n_checks++; if (mv_seen != 0) begin n_fail++; $display("FAIL to_no_mv: got %0d pulses expected 0", mv_seen); end
        n_checks++; if (locked !== 0) begin n_fail++; $display("FAIL to_locked: got %0b expected 0", locked); end
        div_req    = 8;
        exp_period = 8;
        mode       = 1;
        wait_mv(40, cyc, got);
        n_checks++; if (!got) begin n_fail++; $display("FAIL to_restart_mv: no meas_valid within bound, expected one"); end
        n_checks++; if (timeout !== 0) begin n_fail++; $display("FAIL to_clear: got %0b expected 0", timeout); end
        n_checks++; if (period !== 8)  begin n_fail++; $display("FAIL to_restart_period: got %0d expected 8", period); end
    endtask

    task automatic test_enable_drop();
        int cyc;
        bit got;
        int post_mv = 0;
        div_req = 10;
        wait_mv(20, cyc, got);
        n_checks++; if (!got || period !== 8) begin n_fail++; $display("FAIL ed_pre_period: got %0d expected 8", period); end
        // the next rise is seen by the DUT on the 10th edge; drop enable just before it
        repeat (9) @(negedge clk_in);
        enable = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk_in);
            if (meas_valid) post_mv++;
        end
        n_checks++; if (post_mv != 0)    begin n_fail++; $display("FAIL ed_no_mv: got %0d pulses expected 0", post_mv); end
        n_checks++; if (period !== 8)    begin n_fail++; $display("FAIL ed_period_kept: got %0d expected 8", period); end
        n_checks++; if (high_time !== 4) begin n_fail++; $display("FAIL ed_high_kept: got %0d expected 4", high_time); end
        n_checks++; if (locked !== 0)    begin n_fail++; $display("FAIL ed_locked: got %0b expected 0", locked); end
        n_checks++; if (timeout !== 0)   begin n_fail++; $display("FAIL ed_timeout: got %0b expected 0", timeout); end
    endtask

    task automatic test_reset_mid();
        int cyc;
        bit got;
        int snap;
        mode       = 0;
        div_req    = 8;
        exp_period = 8;
        repeat (2) @(negedge clk_in);
        enable = 1'b1;
        mode   = 1;
        for (int k = 1; k <= 4; k++) begin
            wait_mv(40, cyc, got);
            n_checks++; if (!got) begin n_fail++; $display("FAIL rm_pre_mv%0d: no meas_valid within bound, expected one", k); end
        end
        n_checks++; if (locked !== 1) begin n_fail++; $display("FAIL rm_pre_locked: got %0b expected 1", locked); end
        repeat (3) @(negedge clk_in);
        rst_n = 1'b0;
        #1;
        n_checks++; if (period !== 0)     begin n_fail++; $display("FAIL rm_period: got %0d expected 0", period); end
        n_checks++; if (high_time !== 0)  begin n_fail++; $display("FAIL rm_high: got %0d expected 0", high_time); end
        n_checks++; if (locked !== 0)     begin n_fail++; $display("FAIL rm_locked: got %0b expected 0", locked); end
        n_checks++; if (timeout !== 0)    begin n_fail++; $display("FAIL rm_timeout: got %0b expected 0", timeout); end
        n_checks++; if (meas_valid !== 0) begin n_fail++; $display("FAIL rm_mv: got %0b expected 0", meas_valid); end
        enable = 1'b0;
        mode   = 0;
        repeat (3) @(negedge clk_in);
        rst_n = 1'b1;
        repeat (2) @(negedge clk_in);
        enable = 1'b1;
        repeat (2) @(negedge clk_in);
        snap = rise_cnt;
        mode = 1;
        wait_mv(40, cyc, got);
        n_checks++; if (!got) begin n_fail++; $display("FAIL rm_post_mv: no meas_valid within bound, expected one"); end
        n_checks++; if (rise_cnt - snap != 2) begin n_fail++; $display("FAIL rm_two_rises: got %0d rises expected 2", rise_cnt - snap); end
        n_checks++; if (period !== 8) begin n_fail++; $display("FAIL rm_post_period: got %0d expected 8", period); end
    endtask

    task automatic test_async();
        int cyc;
        bit got;
        enable     = 1'b0;
        exp_period = 7;
        mode       = 2;
        repeat (3) @(negedge clk_in);
        enable = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            wait_mv(30, cyc, got);
            n_checks++; if (!got) begin n_fail++; $display("FAIL as_mv%0d: no meas_valid within bound, expected one", k); end
            n_checks++; if (period < 7 || period > 8) begin n_fail++; $display("FAIL as_period%0d: got %0d expected 7 or 8", k, period); end
            n_checks++; if (high_time < 3 || high_time > 4) begin n_fail++; $display("FAIL as_high%0d: got %0d expected 3 or 4", k, high_time); end
            n_checks++; if (locked !== (k >= 4)) begin n_fail++; $display("FAIL as_locked%0d: got %0b expected %0b", k, locked, (k >= 4)); end
        end
        enable = 1'b0;
        mode   = 0;
    endtask

    initial begin
        test_reset();
        test_divide8();
        test_switch12();
        test_timeout();
        test_enable_drop();
        test_reset_mid();
        test_async();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/clk_period_meter.md
CLK_PERIOD_METER -- requirements
Module: clk_period_meter

Interface
REQ-001 SHALL have parameter CNT_W, default 21, meaning width of all cycle counters and measurement outputs.
REQ-002 SHALL have parameter SYNC_STAGES, default 2, meaning synchronizer depth on sig_in, legal range 2..4.
REQ-003 SHALL have parameter TIMEOUT, default 1000000, meaning the cycle limit with no rising edge before timeout; 2 <= TIMEOUT <= 2^CNT_W-1.
REQ-004 SHALL have parameter LOCK_TOL, default 1, meaning the maximum |period - exp_period| counted as a good measurement.
REQ-005 SHALL have parameter LOCK_COUNT, default 4, meaning the number of consecutive good measurements needed to assert locked; minimum 1.
REQ-006 SHALL have port clk_in, input, 1 bit: measurement clock; all logic on its rising edge.
REQ-007 SHALL have port rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-008 SHALL have port sig_in, input, 1 bit: measured clock, asynchronous to clk_in (typically a divided clock).
REQ-009 SHALL have port enable, input, 1 bit: measurement enable, synchronous to clk_in.
REQ-010 SHALL have port exp_period, input, CNT_W bits: expected period in clk_in cycles.
REQ-011 SHALL have port period, output, CNT_W bits: last measured rise-to-rise interval.
REQ-012 SHALL have port high_time, output, CNT_W bits: last measured rise-to-fall interval.
REQ-013 SHALL have port meas_valid, output, 1 bit: one-cycle pulse when period/high_time update.
REQ-014 SHALL have port timeout, output, 1 bit: sticky no-edge indication.
REQ-015 SHALL have port locked, output, 1 bit: period within tolerance for LOCK_COUNT consecutive measurements.

Function
REQ-016 SHALL pass sig_in through a SYNC_STAGES flop synchronizer followed by one history flop; rise = sync_out & ~hist, fall = ~sync_out & hist.
REQ-017 SHALL implement FSM IDLE/ARM/MEASURE; enable=0 in any state forces IDLE on the next edge, and this takes priority over all other events.
REQ-018 SHALL, in IDLE with enable=1, go to ARM with the cycle counter cnt cleared to 0.
REQ-019 SHALL, in ARM, increment cnt each cycle; on rise go to MEASURE with cnt<=1, and produce no meas_valid.
REQ-020 SHALL, in MEASURE, increment cnt each cycle; on fall capture cnt into an internal high register.
REQ-021 SHALL, in MEASURE on rise, register period<=cnt, high_time<=captured high value, pulse meas_valid for exactly one cycle, clear timeout, and set cnt<=1.
REQ-022 SHALL define the period of a 50%-duty divide-by-N clock synchronous to clk_in as period=N, high_time=N/2.
REQ-023 SHALL, in ARM or MEASURE, when cnt==TIMEOUT and no rise occurs in that cycle, set timeout=1, clear locked and the good counter, set cnt<=0, and go to ARM; rise in the same cycle wins, giving a normal measurement.
REQ-024 SHALL never let cnt wrap; the TIMEOUT bound guarantees this.
REQ-025 SHALL, on each meas_valid, compute |period_new - exp_period| at CNT_W+1 bits; if <= LOCK_TOL, increment a saturating good counter, else clear it and drop locked.
REQ-026 SHALL assert locked in the cycle meas_valid is asserted when the good counter reaches LOCK_COUNT, and hold it until a bad measurement, timeout, or leaving MEASURE.
REQ-027 SHALL, on entering IDLE, clear locked, timeout, the good counter and cnt, and retain period and high_time.
REQ-028 SHALL, when enable falls in the same cycle as rise, produce no meas_valid and no update.
REQ-029 SHALL update period and high_time only together with meas_valid.

Reset
REQ-030 SHALL, while rst_n=0, asynchronously force period=0, high_time=0, meas_valid=0, timeout=0, locked=0, FSM=IDLE, synchronizer and history flops=0, and all counters=0.
REQ-031 SHALL, on rst_n release, start in IDLE; the first rise after enable only arms, and the first meas_valid follows the second rise.
REQ-032 SHALL, on reset asserted mid-measurement, discard the partial measurement without a meas_valid pulse.

Verification
REQ-033 Bench SHALL cover: sig_in = clk_in/8, 50% duty, enable=1, exp_period=8 -> meas_valid every 8 cycles, period=8, high_time=4, locked=1 on the 4th meas_valid.
REQ-034 Bench SHALL cover: locked at exp_period=8, then sig_in switched to /12 -> next meas_valid period=12, locked drops that cycle; exp_period changed to 12 -> relock after 4 measurements.
REQ-035 Bench SHALL cover: TIMEOUT=50, sig_in held low after locking -> timeout=1 exactly 50 cycles after the last rise, locked=0; restart /8 -> first meas_valid clears timeout.
REQ-036 Bench SHALL cover: enable dropped in the rise cycle -> no meas_valid; period keeps its old value; locked=0, timeout=0.
REQ-037 Bench SHALL cover: rst_n pulsed low mid-period -> all outputs 0 immediately; after release and enable, the first meas_valid occurs only after two rises.
REQ-038 Bench SHALL cover: asynchronous sig_in of period 7.3 clk_in cycles -> every period value is 7 or 8, and locked=1 with exp_period=7, LOCK_TOL=1.
